bus_sequencer: RTL

Multi-cycle register-transfer sequencer for the 16-bit CPU's shared data bus. It accepts one instruction at a time through a valid/ready handshake. It then drives the 5-bit register bus-select code, one-hot register load enables and ALU latch enables cycle by cycle to execute a register move or a two-operand ALU operation. It sits between the instruction source (front panel switches or fetch unit) and the register file / bus mux / ALU datapath.

---
 rtl/bus_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bus_sequencer.sv
// bus_sequencer: multi-cycle register-transfer sequencer for the 16-bit CPU's
// shared data bus. It accepts one instruction at a time through a valid/ready
// handshake. It then steps through bus-select, register-load and ALU-latch
// controls to perform a register move or a two-operand ALU operation.
// Every output is a flop. The next-state logic also produces the output values
// for that next state, so there is no combinational path from input to output.
module bus_sequencer #(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [4:0]          bus_sel,
  output logic [NUM_REGS-1:0] reg_load,
  output logic                alu_a_load,
  output logic                alu_b_load,
  output logic [3:0]          alu_op,
  output logic                alu_out_en,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_OPA,
    S_OPB,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_NOP = 4'h8;
  localparam logic [NUM_REGS-1:0] LOAD_ONE = NUM_REGS'(1);

  // Opcodes 0x1..0x7 are two-operand ALU operations.
  function automatic logic is_alu(input logic [3:0] op);
    return (op != OP_MOV) && !op[3];
  endfunction

  // Opcodes 0x9..0xF are not defined.
  function automatic logic is_illegal(input logic [3:0] op);
    return op[3] && (op != OP_NOP);
  endfunction

  // Bus-select code for register r: code 0 means the bus is idle.
  function automatic logic [4:0] bus_code(input logic [3:0] r);
    return {1'b0, r} + 5'd1;
  endfunction

  state_t     state, nxt_state;
  logic [3:0] opc_q, dst_q, src_q;
  logic [3:0] nxt_opc, nxt_dst, nxt_src;
  logic       accept;

  logic                nxt_ready;
  logic [4:0]          nxt_bus_sel;
  logic [NUM_REGS-1:0] nxt_reg_load;
  logic                nxt_alu_a_load;
  logic                nxt_alu_b_load;
  logic [3:0]          nxt_alu_op;
  logic                nxt_alu_out_en;
  logic                nxt_done;
  logic                nxt_err;

  // The low nibble of the instruction is reserved and carries no meaning.
  logic unused_reserved;
  assign unused_reserved = ^instr[3:0];

  // instr_ready is a flop that is high only in IDLE, so accept never depends on
  // a combinational ready.
  assign accept = instr_valid & instr_ready;

  // Next-state logic. The operand fields are captured once, on accept.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    nxt_state = state;
    nxt_opc   = opc_q;
    nxt_dst   = dst_q;
    nxt_src   = src_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          nxt_opc = instr[15:12];
          nxt_dst = instr[11:8];
          nxt_src = instr[7:4];
          if (instr[15:12] == OP_MOV)     nxt_state = S_XFER;
          else if (is_alu(instr[15:12]))  nxt_state = S_OPA;
          else                            nxt_state = S_DONE;
        end
      end
      S_XFER:  nxt_state = S_DONE;
      S_OPA:   nxt_state = S_OPB;
      S_OPB:   nxt_state = S_WB;
      S_WB:    nxt_state = S_DONE;
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Decode the output values for the state being entered, so they can be
  // registered together with it.
  always_comb begin
    nxt_ready      = (nxt_state == S_IDLE);
    nxt_bus_sel    = 5'd0;
    nxt_reg_load   = '0;
    nxt_alu_a_load = 1'b0;
    nxt_alu_b_load = 1'b0;
    nxt_alu_out_en = 1'b0;
    nxt_done       = 1'b0;
    nxt_err        = 1'b0;
    nxt_alu_op     = (nxt_state != S_IDLE && is_alu(nxt_opc)) ? nxt_opc : 4'h0;
    case (nxt_state)
      S_XFER: begin
        nxt_bus_sel  = bus_code(nxt_src);
        nxt_reg_load = LOAD_ONE << nxt_dst;
      end
      S_OPA: begin
        nxt_bus_sel    = bus_code(nxt_src);
        nxt_alu_a_load = 1'b1;
      end
      S_OPB: begin
        nxt_bus_sel    = bus_code(nxt_dst);
        nxt_alu_b_load = 1'b1;
      end
      S_WB: begin
        // The ALU drives the bus here, so no register select may be active.
        nxt_alu_out_en = 1'b1;
        nxt_reg_load   = LOAD_ONE << nxt_dst;
      end
      S_DONE: begin
        nxt_done = 1'b1;
        nxt_err  = is_illegal(nxt_opc);
      end
      default: ;
    endcase
  end

  // State, captured operand fields and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the captured fields are ordinary control flops, not storage
      // arrays, so they are reset together with the state.
      state       <= S_IDLE;
      opc_q       <= 4'h0;
      dst_q       <= 4'h0;
      src_q       <= 4'h0;
      instr_ready <= 1'b0;
      bus_sel     <= 5'd0;
      reg_load    <= '0;
      alu_a_load  <= 1'b0;
      alu_b_load  <= 1'b0;
      alu_op      <= 4'h0;
      alu_out_en  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples values from
      // before the edge, whatever order the statements appear in.
      state       <= nxt_state;
      opc_q       <= nxt_opc;
      dst_q       <= nxt_dst;
      src_q       <= nxt_src;
      instr_ready <= nxt_ready;
      bus_sel     <= nxt_bus_sel;
      reg_load    <= nxt_reg_load;
      alu_a_load  <= nxt_alu_a_load;
      alu_b_load  <= nxt_alu_b_load;
      alu_op      <= nxt_alu_op;
      alu_out_en  <= nxt_alu_out_en;
      done        <= nxt_done;
      err         <= nxt_err;
    end
  end

  // Bus and handshake invariants.
  a_single_driver: assert property (@(posedge clk) disable iff (!reset_n)
    !(alu_out_en && (bus_sel != 5'd0)));
  a_load_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(reg_load));
  a_ready_not_done: assert property (@(posedge clk) disable iff (!reset_n)
    !(instr_ready && done));

endmodule
